aux_io_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single aux_io control interface among NUM_REQ requesters.

---
 rtl/aux_io_arbiter.sv | 177 +++++++++++++++++
 tb/tb_aux_io_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_io_arbiter.sv
// Round-robin arbiter that shares the single aux_io request port among NUM_REQ requesters.
// It keeps one transaction outstanding, with an optional timeout abort while waiting.
`timescale 1ns/1ps
module aux_io_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ-1:0]      req_write_i,
    input  logic [32*NUM_REQ-1:0]   req_wdata_i,
    input  logic [17*NUM_REQ-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]      req_done_o,
    output logic [NUM_REQ-1:0]      req_err_o,
    output logic [31:0]             req_rdata_o,
    output logic                    arb_busy_o,
    output logic                    aux_write_req_o,
    output logic                    aux_read_req_o,
    output logic [31:0]             aux_data_write_o,
    output logic [16:0]             aux_address_o,
    input  logic [31:0]             aux_data_read_i,
    input  logic                    aux_busy_i
);
    // state | meaning
    // IDLE  | waiting for a valid request while aux_io is not busy
    // ISSUE | aux request pulse is visible to aux_io
    // WAIT  | waiting for aux_busy to fall, or for the timeout
    // DONE  | done/err pulse is visible; round-robin pointer advances
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       gnt_q, gnt_d;
    logic                rw_q, rw_d;
    logic [15:0]         timer_q, timer_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                wreq_q, wreq_d;
    logic                rreq_q, rreq_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [16:0]         addr_q, addr_d;

    logic [IW-1:0]       pick;
    logic                pick_vld;
    logic [IW-1:0]       scan_idx;
    logic                sel_write;
    logic [16:0]         sel_addr;
    logic [31:0]         sel_wdata;

    // The scan starts just after the last-served requester, so that requester has the lowest priority.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_vld && req_valid_i[scan_idx]) begin
                pick     = scan_idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IW'(i)) begin
                sel_write = req_write_i[i];
                sel_addr  = req_addr_i[17*i +: 17];
                sel_wdata = req_wdata_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        rw_d     = rw_q;
        timer_d  = timer_q;
        done_d   = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        wreq_d   = 1'b0;
        rreq_d   = 1'b0;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld && !aux_busy_i) begin
                    gnt_d   = pick;
                    rw_d    = sel_write;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wreq_d  = sel_write;
                    rreq_d  = !sel_write;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!aux_busy_i) begin
                    if (!rw_q) begin
                        rdata_d = aux_data_read_i;
                    end
                    done_d[gnt_q] = 1'b1;
                    state_d       = DONE;
                end else if (TIMEOUT_CYCLES != 0 && timer_q == TO_LAST) begin
                    done_d[gnt_q] = 1'b1;
                    err_d[gnt_q]  = 1'b1;
                    state_d       = DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DONE: begin
                rr_ptr_d = gnt_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= IW'(NUM_REQ - 1);
            gnt_q    <= '0;
            rw_q     <= 1'b0;
            timer_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            wreq_q   <= 1'b0;
            rreq_q   <= 1'b0;
            wdata_q  <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            rw_q     <= rw_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            wreq_q   <= wreq_d;
            rreq_q   <= rreq_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
        end
    end

    assign req_done_o       = done_q;
    assign req_err_o        = err_q;
    assign req_rdata_o      = rdata_q;
    assign arb_busy_o       = busy_q;
    assign aux_write_req_o  = wreq_q;
    assign aux_read_req_o   = rreq_q;
    assign aux_data_write_o = wdata_q;
    assign aux_address_o    = addr_q;

endmodule

// File: tb/tb_aux_io_arbiter.sv
// Scoreboard bench for aux_io_arbiter: stimulus pushes expected completions and aux pulses,
// and monitors pop and compare them as the DUT presents them.
`timescale 1ns/1ps
module tb_aux_io_arbiter;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_write = '0;
    logic [32*NR-1:0]  req_wdata = '0;
    logic [17*NR-1:0]  req_addr = '0;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic [31:0]       req_rdata;
    logic              arb_busy;
    logic              aux_write_req;
    logic              aux_read_req;
    logic [31:0]       aux_data_write;
    logic [16:0]       aux_address;
    logic [31:0]       aux_data_read;
    logic              aux_busy;

    aux_io_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_write_i(req_write),
        .req_wdata_i(req_wdata), .req_addr_i(req_addr),
        .req_done_o(req_done), .req_err_o(req_err), .req_rdata_o(req_rdata),
        .arb_busy_o(arb_busy),
        .aux_write_req_o(aux_write_req), .aux_read_req_o(aux_read_req),
        .aux_data_write_o(aux_data_write), .aux_address_o(aux_address),
        .aux_data_read_i(aux_data_read), .aux_busy_i(aux_busy)
    );

    always #5 clk = ~clk;

    // aux_io model: busy during the request cycle and one cycle after; hang keeps it busy.
    logic        busy_cnt = 1'b0;
    logic        stuck = 1'b0;
    logic        hang = 1'b0;
    logic        force_busy = 1'b0;
    logic [31:0] rd_ret = '0;

    always @(posedge clk) begin
        if (aux_write_req || aux_read_req) begin
            busy_cnt <= 1'b1;
            if (hang) stuck <= 1'b1;
        end else begin
            busy_cnt <= 1'b0;
        end
        if (!hang) stuck <= 1'b0;
    end
    assign aux_busy      = aux_write_req | aux_read_req | busy_cnt | stuck | force_busy;
    assign aux_data_read = aux_busy ? 32'h0 : rd_ret;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    typedef struct {
        int          idx;
        bit          err;
        bit          chk_rd;
        logic [31:0] rdata;
        int          lat;
        int          start;
    } done_t;
    typedef struct {
        bit          wr;
        logic [16:0] addr;
        logic [31:0] wdata;
    } aux_t;

    done_t dq[$];
    aux_t  aq[$];
    done_t de;
    aux_t  ae;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (req_done != '0 || req_err != '0)) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual done=%b err=%b required none", req_done, req_err);
            end else begin
                de = dq.pop_front();
                chk("done_vec", 64'(req_done), 64'(1 << de.idx));
                chk("err_vec", 64'(req_err), de.err ? 64'(1 << de.idx) : 64'h0);
                if (de.chk_rd) chk("rdata", 64'(req_rdata), 64'(de.rdata));
                if (de.lat >= 0) chk("done_latency", 64'(cyc - de.start), 64'(de.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (aux_write_req || aux_read_req)) begin
            pulse_cnt++;
            chk("aux_single_kind", 64'(aux_write_req & aux_read_req), 64'h0);
            if (aq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_aux_pulse actual wr=%b rd=%b addr=%h required none",
                         aux_write_req, aux_read_req, aux_address);
            end else begin
                ae = aq.pop_front();
                chk("aux_write_req", 64'(aux_write_req), 64'(ae.wr));
                chk("aux_address", 64'(aux_address), 64'(ae.addr));
                chk("aux_data_write", 64'(aux_data_write), 64'(ae.wdata));
            end
        end
    end

    function automatic logic [16:0] fair_addr(input int i);
        return 17'(32'h10000 + i * 32'h111);
    endfunction
    function automatic logic [31:0] fair_wdata(input int i);
        return 32'hA5A50000 + 32'(i);
    endfunction

    task automatic expect_txn(input int i, input bit w, input logic [16:0] a, input logic [31:0] d,
                              input bit err, input bit chk_rd, input logic [31:0] rd, input int lat);
        done_t e;
        aux_t  x;
        e.idx = i; e.err = err; e.chk_rd = chk_rd; e.rdata = rd; e.lat = lat; e.start = cyc + 1;
        x.wr = w; x.addr = a; x.wdata = d;
        dq.push_back(e);
        aq.push_back(x);
    endtask

    task automatic drive_req(input int i, input bit w, input logic [16:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        req_write[i] = w;
        req_addr[17*i +: 17] = a;
        req_wdata[32*i +: 32] = d;
        req_valid[i] = 1'b1;
        n = 0;
        while (req_done[i] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL req%0d_wait actual no req_done after %0d cycles required req_done", i, n);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic txn(input int i, input bit w, input logic [16:0] a, input logic [31:0] d,
                       input bit err, input bit chk_rd, input logic [31:0] rd, input int lat);
        expect_txn(i, w, a, d, err, chk_rd, rd, lat);
        drive_req(i, w, a, d);
    endtask

    task automatic rr_worker(input int i);
        for (int n = 0; n < 3; n++) drive_req(i, (i % 2) == 0, fair_addr(i), fair_wdata(i));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, 64'(req_done), 64'h0);
        chk({tag, "_err"}, 64'(req_err), 64'h0);
        chk({tag, "_rdata"}, 64'(req_rdata), 64'h0);
        chk({tag, "_busy"}, 64'(arb_busy), 64'h0);
        chk({tag, "_wreq"}, 64'(aux_write_req), 64'h0);
        chk({tag, "_rreq"}, 64'(aux_read_req), 64'h0);
        chk({tag, "_wdata"}, 64'(aux_data_write), 64'h0);
        chk({tag, "_addr"}, 64'(aux_address), 64'h0);
    endtask

    int c0;
    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // single write, then single read, both with nominal 4-cycle latency
        txn(1, 1'b1, 17'h000A5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 4);
        rd_ret = 32'h12345678;
        txn(2, 1'b0, 17'h1F00F, 32'h0, 1'b0, 1'b1, 32'h12345678, 4);
        repeat (3) @(posedge clk);
        #1;
        chk("rdata_hold", 64'(req_rdata), 64'h12345678);

        // cancel: request 3 while aux_io is busy, then withdraw
        c0 = pulse_cnt;
        force_busy = 1'b1;
        @(posedge clk); #1;
        req_valid[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        @(posedge clk); #1;
        force_busy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("cancel_pulses", 64'(pulse_cnt - c0), 64'h0);
        chk("cancel_busy", 64'(arb_busy), 64'h0);

        // highest-index requester; a write must leave the last read data in place
        txn(3, 1'b1, 17'h1FFFF, 32'hFFFF0001, 1'b0, 1'b0, 32'h0, 4);
        chk("rdata_hold_after_write", 64'(req_rdata), 64'h12345678);

        // fairness: all four contend for three rounds
        rd_ret = 32'hCAFEF00D;
        c0 = pulse_cnt;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NR; i++)
                expect_txn(i, (i % 2) == 0, fair_addr(i), fair_wdata(i), 1'b0, (i % 2) == 1,
                           32'hCAFEF00D, -1);
        fork
            rr_worker(0);
            rr_worker(1);
            rr_worker(2);
            rr_worker(3);
        join
        chk("fair_pulses", 64'(pulse_cnt - c0), 64'd12);

        // timeout: aux_io hangs; the next grant waits until aux_io recovers
        hang = 1'b1;
        txn(0, 1'b1, 17'h00001, 32'h11112222, 1'b1, 1'b0, 32'h0, 18);
        expect_txn(1, 1'b1, 17'h00002, 32'h33334444, 1'b0, 1'b0, 32'h0, -1);
        fork
            drive_req(1, 1'b1, 17'h00002, 32'h33334444);
            begin
                c0 = pulse_cnt;
                repeat (10) @(posedge clk);
                #1;
                chk("to_withheld_pulses", 64'(pulse_cnt - c0), 64'h0);
                chk("to_withheld_busy", 64'(arb_busy), 64'h0);
                hang = 1'b0;
            end
        join

        // reset while waiting on a hung read aborts silently
        begin
            aux_t x;
            x.wr = 1'b0; x.addr = 17'h0ABCD; x.wdata = 32'h0;
            aq.push_back(x);
        end
        hang = 1'b1;
        @(posedge clk); #1;
        req_write[2] = 1'b0;
        req_addr[2*17 +: 17] = 17'h0ABCD;
        req_wdata[2*32 +: 32] = 32'h0;
        req_valid[2] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(arb_busy), 64'h1);
        reset = 1'b1;
        req_valid[2] = 1'b0;
        hang = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_all_zero("midreset");
        expect_txn(0, 1'b1, 17'h00AAA, 32'h0BADF00D, 1'b0, 1'b0, 32'h0, -1);
        expect_txn(3, 1'b0, 17'h00BBB, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, -1);
        fork
            drive_req(0, 1'b1, 17'h00AAA, 32'h0BADF00D);
            drive_req(3, 1'b0, 17'h00BBB, 32'h0);
        join

        n = 0;
        while ((dq.size() != 0 || aq.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("done_queue_drained", 64'(dq.size()), 64'h0);
        chk("aux_queue_drained", 64'(aq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "bench time limit");
    end
endmodule
